// File: rtl/lift_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_ctrl
// Description : Call-button synchroniser/debouncer, pending-request latches
//               and slowref prescaler feeding the lift state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_req_ctrl #(
    parameter int SLOW_DIV = 50,
    parameter int DB_LEN   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up0,
    input  logic btn_up1,
    input  logic btn_dn1,
    input  logic btn_dn2,
    input  logic btn_fl0,
    input  logic btn_fl1,
    input  logic btn_fl2,
    input  logic clrup0,
    input  logic clrup1,
    input  logic clrdn1,
    input  logic clrdn2,
    input  logic clr_flreq0,
    input  logic clr_flreq1,
    input  logic clr_flreq2,
    input  logic cancel_all,
    output logic upreq0,
    output logic upreq1,
    output logic dnreq1,
    output logic dnreq2,
    output logic flreq0,
    output logic flreq1,
    output logic flreq2,
    output logic slowref,
    output logic any_req
);

    localparam int c_NCH   = 7;
    localparam int c_CNT_W = $clog2(DB_LEN + 1);
    localparam int c_PC_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_DB_MAX  = c_CNT_W'(DB_LEN);
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_LEN - 1);
    localparam logic [c_PC_W-1:0]  c_PC_LAST = c_PC_W'(SLOW_DIV - 1);

    logic [c_NCH-1:0]  w_btn;
    logic [c_NCH-1:0]  w_clr;
    logic [c_NCH-1:0]  w_press;
    logic [c_NCH-1:0]  r_sync1;
    logic [c_NCH-1:0]  r_sync2;
    logic [c_NCH-1:0]  r_pend;
    logic [c_PC_W-1:0] r_pc;
    logic              r_slowref;

    // Channel order: up0, up1, dn1, dn2, fl0, fl1, fl2
    assign w_btn = {btn_fl2, btn_fl1, btn_fl0, btn_dn2, btn_dn1, btn_up1, btn_up0};
    assign w_clr = {clr_flreq2, clr_flreq1, clr_flreq0, clrdn2, clrdn1, clrup1, clrup0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar g = 0; g < c_NCH; g++) begin : g_ch
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset || !r_sync2[g]) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_DB_MAX) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            // Fires once as the counter crosses into saturation; held
            // presses stay parked at c_DB_MAX until the line drops.
            assign w_press[g] = r_sync2[g] && (r_cnt == c_DB_LAST);
        end
    endgenerate

    // A press outranks any clear in the same cycle so no call is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_press | (r_pend & ~(w_clr | {c_NCH{cancel_all}}));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_slowref <= 1'b0;
        end else begin
            r_pc      <= (r_pc == c_PC_LAST) ? '0 : r_pc + c_PC_W'(1);
            r_slowref <= (r_pc == c_PC_LAST);
        end
    end

    assign upreq0  = r_pend[0];
    assign upreq1  = r_pend[1];
    assign dnreq1  = r_pend[2];
    assign dnreq2  = r_pend[3];
    assign flreq0  = r_pend[4];
    assign flreq1  = r_pend[5];
    assign flreq2  = r_pend[6];
    assign slowref = r_slowref;
    assign any_req = |r_pend;

endmodule
`default_nettype wire

// File: doc/lift_req_ctrl.md
Name: lift_req_ctrl

Overview:
- Front-end request manager for the lift state machine.
- Synchronises and debounces the seven raw call buttons (hall up/down, car floor), and latches each press into a pending-request bit that drives the lift SM request inputs and the button lamps.
- Clears each pending bit on the matching clear strobe from the lift SM.
- Generates the slowref tick that paces the lift SM.

Parameters:
- SLOW_DIV, 50, clk cycles per slowref pulse (>=1)
- DB_LEN, 4, consecutive synchronised-high clk cycles required to accept a press (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- btn_up0, btn_up1, btn_dn1, btn_dn2  in  1 each  raw hall-call buttons, asynchronous, active-high
- btn_fl0, btn_fl1, btn_fl2  in  1 each  raw car floor buttons, asynchronous, active-high
- clrup0, clrup1, clrdn1, clrdn2  in  1 each  hall-call clear strobes from lift SM
- clr_flreq0, clr_flreq1, clr_flreq2  in  1 each  floor-request clear strobes from lift SM
- cancel_all  in  1  synchronous clear of every pending request (fire/service mode)
- upreq0, upreq1, dnreq1, dnreq2  out  1 each  pending hall calls to lift SM; also lamp drives
- flreq0, flreq1, flreq2  out  1 each  pending floor requests to lift SM; also lamp drives
- slowref  out  1  one-clk tick every SLOW_DIV clks
- any_req  out  1  OR of all seven pending bits

Behaviour:
- Reset (reset=1 at a clk edge): all pending bits 0, all sync/debounce state 0, prescaler 0, slowref 0, any_req 0. Reset dominates every other input, and an in-progress debounce is discarded.
- Synchroniser: each button passes through a 2-flop synchroniser, giving s.
- Debounce, per channel:
  - Counter cnt of width clog2(DB_LEN+1).
  - s=0: cnt<=0.
  - s=1 and cnt<DB_LEN: cnt<=cnt+1.
  - Saturates at DB_LEN.
  - press is a one-clk pulse when s=1 and cnt==DB_LEN-1, so exactly one press per held assertion.
  - Re-arming requires at least one s=0 cycle.
  - Glitches shorter than DB_LEN synchronised cycles produce no press.
- Latency: a button steady high from edge t sets its pending output after edge t+DB_LEN+1, i.e. visible in the cycle following the (DB_LEN+2)th edge.
- Pending bit update, per channel, in priority order:
  1. reset: 0
  2. press: 1 (a new press beats a same-cycle clear or cancel_all, so no request is lost)
  3. cancel_all or the matching clr: 0
  4. otherwise hold
- Clear strobes are level inputs. Any cycle with clr=1 clears, regardless of slowref, because the lift SM holds its clears for a whole slowref period. A pending bit set while its clr is still high is cleared on the following cycle unless press repeats. This is accepted behaviour.
- Pressing an already-pending button has no effect (stays 1).
- Channels are fully independent. Simultaneous presses on several buttons all latch in the same cycle.
- Prescaler:
  - Counter pc of width clog2(SLOW_DIV), counting 0..SLOW_DIV-1 and wrapping to 0.
  - slowref=1 exactly when pc==SLOW_DIV-1, and is registered.
  - First slowref after reset release occurs SLOW_DIV cycles later.
  - SLOW_DIV=1: slowref held 1 every cycle after the first post-reset edge.
- any_req is combinational OR of registered pending bits; no additional latency.
- All outputs are registered except any_req.

Test Plan:
1. Reset: assert reset 3 cycles with all buttons high -> every req output 0, slowref 0, any_req 0. After release with buttons still high, flreq/upreq rise 6 cycles later (DB_LEN=4).
2. Debounce: btn_fl2 high 3 cycles then low -> flreq2 stays 0. Hold btn_fl2 high 20 cycles -> flreq2 rises after the 6th edge and remains 1 with exactly one press pulse. Release and re-press -> still 1, no glitch.
3. Clear: upreq1 pending, pulse clrup1 for 1 cycle -> upreq1 0 the next cycle. Hold clrdn2 high for 10 cycles with dnreq2 pending -> 0 after the first edge and stays 0.
4. Press/clear collision: align the btn_dn1 press pulse with clrdn1=1 in the same cycle -> dnreq1=1 after that edge. Repeat with cancel_all -> dnreq1=1, all other pending bits 0.
5. Prescaler (SLOW_DIV=50): count clocks between slowref pulses -> exactly 50 apart, each 1 cycle wide. First pulse 50 cycles after reset release. Rerun with SLOW_DIV=1 -> slowref constant 1.
6. Integration with lift_sm: press btn_fl2 with the car at floor 0 -> flreq2 latches, lift SM moves up and asserts clr_flreq2 on arrival -> flreq2 returns 0 and any_req drops to 0.
